// File: rtl/ssd_decoder_if.sv
// Display-bus capture interface for ssd_decoder: sampled anode/segment/dp lines and decoded frame outputs.
// err_cnt exists only when SSD_DEC_ERR_CNT_EN is defined.
interface ssd_decoder_if;
    logic [3:0]  ssd_anode;
    logic [6:0]  ssd_seg;
    logic        ssd_dp;
    logic [15:0] data_out;
    logic [3:0]  dp_out;
    logic        frame_valid;
    logic        frame_err;
`ifdef SSD_DEC_ERR_CNT_EN
    logic [7:0]  err_cnt;

    modport master (output ssd_anode, ssd_seg, ssd_dp,
                    input  data_out, dp_out, frame_valid, frame_err, err_cnt);
    modport slave  (input  ssd_anode, ssd_seg, ssd_dp,
                    output data_out, dp_out, frame_valid, frame_err, err_cnt);
`else
    modport master (output ssd_anode, ssd_seg, ssd_dp,
                    input  data_out, dp_out, frame_valid, frame_err);
    modport slave  (input  ssd_anode, ssd_seg, ssd_dp,
                    output data_out, dp_out, frame_valid, frame_err);
`endif
endinterface

// File: rtl/ssd_decoder.sv
// Reconstructs a 4-digit hex value and decimal points from a multiplexed seven-segment bus.
// Optional SSD_DEC_ERR_CNT_EN adds a saturating count of undecodable digit captures.
module ssd_decoder #(
    parameter int STABLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic         clk,
    input  logic         rst,
    ssd_decoder_if.slave bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_HELD   = 2'd2;
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [7:0]      STABLE_MAX = 8'(STABLE_CYC);
    localparam logic [TO_W-1:0] TO_MAX     = TO_W'(TIMEOUT_CYC);

    // Returns {invalid, nibble}; undecodable patterns yield nibble 0 with invalid set.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        case (seg)
            7'h40:   seg_decode = 5'h00;
            7'h79:   seg_decode = 5'h01;
            7'h24:   seg_decode = 5'h02;
            7'h30:   seg_decode = 5'h03;
            7'h19:   seg_decode = 5'h04;
            7'h12:   seg_decode = 5'h05;
            7'h02:   seg_decode = 5'h06;
            7'h78:   seg_decode = 5'h07;
            7'h00:   seg_decode = 5'h08;
            7'h10:   seg_decode = 5'h09;
            7'h08:   seg_decode = 5'h0A;
            7'h03:   seg_decode = 5'h0B;
            7'h46:   seg_decode = 5'h0C;
            7'h21:   seg_decode = 5'h0D;
            7'h06:   seg_decode = 5'h0E;
            7'h0E:   seg_decode = 5'h0F;
            default: seg_decode = 5'h10;
        endcase
    endfunction

    function automatic logic is_onehot_low(input logic [3:0] an);
        logic [3:0] a;
        a = ~an;
        is_onehot_low = (a != 4'd0) && ((a & (a - 4'd1)) == 4'd0);
    endfunction

    logic [3:0]      anode_r;
    logic [6:0]      seg_r;
    logic            dp_r;
    logic [7:0]      cnt_r,   cnt_nxt_s;
    logic [1:0]      state_r, state_nxt_s;
    logic [3:0]      mask_r,  mask_nxt_s;
    logic [15:0]     digits_r, digits_nxt_s;
    logic [3:0]      dps_r,   dps_nxt_s;
    logic [3:0]      errs_r,  errs_nxt_s;
    logic [TO_W-1:0] to_cnt_r, to_cnt_nxt_s;
    logic [15:0]     data_out_r;
    logic [3:0]      dp_out_r;
    logic            frame_valid_r, frame_err_r;
    logic            same_s, capture_s, frame_done_s, frame_err_s;
    logic [1:0]      idx_s;
    logic [4:0]      dec_s;

    assign same_s    = ({bus.ssd_anode, bus.ssd_seg, bus.ssd_dp} == {anode_r, seg_r, dp_r});
    assign capture_s = same_s && is_onehot_low(anode_r) && (state_r == ST_SETTLE)
                       && (cnt_r == STABLE_MAX - 8'd1);
    assign dec_s     = seg_decode(seg_r);

    // Stability counter and IDLE/SETTLE/HELD tracking of the registered sample.
    always_comb begin
        cnt_nxt_s   = 8'd0;
        state_nxt_s = ST_IDLE;
        if (!same_s) begin
            state_nxt_s = is_onehot_low(bus.ssd_anode) ? ST_SETTLE : ST_IDLE;
        end else if (!is_onehot_low(anode_r)) begin
            state_nxt_s = ST_IDLE;
        end else if (cnt_r >= STABLE_MAX) begin
            cnt_nxt_s   = STABLE_MAX;
            state_nxt_s = ST_HELD;
        end else begin
            cnt_nxt_s   = cnt_r + 8'd1;
            state_nxt_s = (cnt_nxt_s == STABLE_MAX) ? ST_HELD : ST_SETTLE;
        end
    end

    // Digit index from the one-hot-low anode sample.
    always_comb begin
        case (anode_r)
            4'b1110: idx_s = 2'd0;
            4'b1101: idx_s = 2'd1;
            4'b1011: idx_s = 2'd2;
            4'b0111: idx_s = 2'd3;
            default: idx_s = 2'd0;
        endcase
    end

    // Partial-frame assembly, frame completion and timeout discard.
    always_comb begin
        digits_nxt_s = digits_r;
        dps_nxt_s    = dps_r;
        errs_nxt_s   = errs_r;
        mask_nxt_s   = mask_r;
        to_cnt_nxt_s = to_cnt_r + TO_W'(1);
        frame_done_s = 1'b0;
        frame_err_s  = 1'b0;
        if (capture_s) begin
            digits_nxt_s[{idx_s, 2'b00} +: 4] = dec_s[3:0];
            dps_nxt_s[idx_s]  = ~dp_r;
            errs_nxt_s[idx_s] = dec_s[4];
            mask_nxt_s[idx_s] = 1'b1;
            to_cnt_nxt_s      = {TO_W{1'b0}};
            // The completing digit is included in the published frame.
            if (mask_nxt_s == 4'hF) begin
                frame_done_s = 1'b1;
                frame_err_s  = |errs_nxt_s;
                mask_nxt_s   = 4'h0;
                errs_nxt_s   = 4'h0;
            end else begin
                frame_done_s = 1'b0;
            end
        end else if (to_cnt_nxt_s == TO_MAX) begin
            mask_nxt_s   = 4'h0;
            errs_nxt_s   = 4'h0;
            to_cnt_nxt_s = {TO_W{1'b0}};
        end else begin
            frame_done_s = 1'b0;
        end
    end

    // State, input sample and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            anode_r       <= 4'hF;
            seg_r         <= 7'h7F;
            dp_r          <= 1'b1;
            cnt_r         <= 8'd0;
            state_r       <= ST_IDLE;
            mask_r        <= 4'h0;
            digits_r      <= 16'h0000;
            dps_r         <= 4'h0;
            errs_r        <= 4'h0;
            to_cnt_r      <= {TO_W{1'b0}};
            data_out_r    <= 16'h0000;
            dp_out_r      <= 4'h0;
            frame_valid_r <= 1'b0;
            frame_err_r   <= 1'b0;
        end else begin
            anode_r       <= bus.ssd_anode;
            seg_r         <= bus.ssd_seg;
            dp_r          <= bus.ssd_dp;
            cnt_r         <= cnt_nxt_s;
            state_r       <= state_nxt_s;
            mask_r        <= mask_nxt_s;
            digits_r      <= digits_nxt_s;
            dps_r         <= dps_nxt_s;
            errs_r        <= errs_nxt_s;
            to_cnt_r      <= to_cnt_nxt_s;
            data_out_r    <= frame_done_s ? digits_nxt_s : data_out_r;
            dp_out_r      <= frame_done_s ? dps_nxt_s : dp_out_r;
            frame_valid_r <= frame_done_s;
            frame_err_r   <= frame_err_s;
        end
    end

    assign bus.data_out    = data_out_r;
    assign bus.dp_out      = dp_out_r;
    assign bus.frame_valid = frame_valid_r;
    assign bus.frame_err   = frame_err_r;

`ifdef SSD_DEC_ERR_CNT_EN
    logic [7:0] err_cnt_r;

    // Saturating count of undecodable captures; only rst clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_r <= 8'd0;
        end else if (capture_s && dec_s[4] && (err_cnt_r != 8'hFF)) begin
            err_cnt_r <= err_cnt_r + 8'd1;
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    assign bus.err_cnt = err_cnt_r;
`endif
endmodule

// File: tb/tb_ssd_decoder.sv
// Scoreboard bench for ssd_decoder: directed display-bus sequences push expected frames,
// a negedge monitor pops and compares on every frame_valid pulse.
module tb_ssd_decoder;
    localparam int STABLE  = 4;
    localparam int TIMEOUT = 40;

    typedef struct packed {
        logic [15:0] d;
        logic [3:0]  p;
        logic        e;
    } frame_t;

    logic clk = 1'b0;
    logic rst;
    frame_t exp_q[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int pulses = 0;
    int last_pulse = 0;
    int prev_pulse = 0;

    always #5 clk = ~clk;

    ssd_decoder_if bus();

    ssd_decoder #(.STABLE_CYC(STABLE), .TIMEOUT_CYC(TIMEOUT)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic show(input int idx, input logic [6:0] seg, input logic dp, input int n);
        logic [3:0] a;
        a = 4'b0001 << idx;
        bus.ssd_anode = ~a;
        bus.ssd_seg   = seg;
        bus.ssd_dp    = dp;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [3:0] an, input int n);
        bus.ssd_anode = an;
        bus.ssd_seg   = 7'h7F;
        bus.ssd_dp    = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_frame(input logic [15:0] d, input logic [3:0] p, input logic e);
        frame_t f;
        f.d = d;
        f.p = p;
        f.e = e;
        exp_q.push_back(f);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: every pulse must match the oldest expected frame.
    initial forever begin
        frame_t f;
        @(negedge clk);
        if (bus.frame_valid === 1'b1) begin
            pulses++;
            prev_pulse = last_pulse;
            last_pulse = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse: got pulse at cycle %0d expected none, data_out=0x%0h",
                         cyc, bus.data_out);
            end else begin
                f = exp_q.pop_front();
                check("frame_data", {16'h0, bus.data_out}, {16'h0, f.d});
                check("frame_dp", {28'h0, bus.dp_out}, {28'h0, f.p});
                check("frame_err", {31'h0, bus.frame_err}, {31'h0, f.e});
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.ssd_anode = 4'hF;
        bus.ssd_seg   = 7'h7F;
        bus.ssd_dp    = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_data", {16'h0, bus.data_out}, 32'h0);
        check("rst_dp", {28'h0, bus.dp_out}, 32'h0);
        check("rst_valid", {31'h0, bus.frame_valid}, 32'h0);
        check("rst_err", {31'h0, bus.frame_err}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(4'hF, 5);

        // Basic frame 3,2,1,0 on digits 0..3.
        show(0, 7'h30, 1'b1, 10);
        show(1, 7'h24, 1'b1, 10);
        show(2, 7'h79, 1'b1, 10);
        expect_frame(16'h0123, 4'h0, 1'b0);
        show(3, 7'h40, 1'b1, 10);
        idle(4'hF, 5);

        // Digit 2 held one cycle short: no frame until it is captured on the second pass.
        show(0, 7'h30, 1'b1, 10);
        show(1, 7'h24, 1'b1, 10);
        show(2, 7'h79, 1'b1, STABLE - 1);
        show(3, 7'h40, 1'b1, 10);
        idle(4'hF, 3);
        check("short_hold_data", {16'h0, bus.data_out}, 32'h0123);
        show(0, 7'h19, 1'b1, 10);
        show(1, 7'h12, 1'b1, 10);
        expect_frame(16'h0654, 4'h0, 1'b0);
        show(2, 7'h02, 1'b1, 10);
        show(3, 7'h78, 1'b1, 10);
        idle(4'hF, TIMEOUT + 5);

        // Undecodable digit 1.
        show(0, 7'h0E, 1'b1, 10);
        show(1, 7'h7F, 1'b1, 10);
        show(2, 7'h06, 1'b1, 10);
        expect_frame(16'hDE0F, 4'h0, 1'b1);
        show(3, 7'h21, 1'b1, 10);
`ifdef SSD_DEC_ERR_CNT_EN
        check("err_cnt_one", {24'h0, bus.err_cnt}, 32'h1);
`endif

        // Timeout discards digits 0-2; lone digit 3 must not complete a frame.
        show(0, 7'h00, 1'b1, 10);
        show(1, 7'h10, 1'b1, 10);
        show(2, 7'h08, 1'b1, 10);
        idle(4'hF, TIMEOUT);
        show(3, 7'h03, 1'b1, 10);
        idle(4'hF, 3);
        check("timeout_hold_data", {16'h0, bus.data_out}, 32'hDE0F);
        show(0, 7'h46, 1'b1, 10);
        show(1, 7'h79, 1'b1, 10);
        expect_frame(16'hB21C, 4'h0, 1'b0);
        show(2, 7'h24, 1'b1, 10);
        show(3, 7'h30, 1'b1, 10);

        // Multi-hot anode never captures; the leftover partial frame also times out.
        idle(4'b1100, 50);
        check("multihot_data", {16'h0, bus.data_out}, 32'hB21C);

        // Reset mid-frame discards digits 0-2.
        show(0, 7'h79, 1'b1, 10);
        show(1, 7'h79, 1'b1, 10);
        show(2, 7'h79, 1'b1, 10);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_data", {16'h0, bus.data_out}, 32'h0);
        check("midrst_dp", {28'h0, bus.dp_out}, 32'h0);
        check("midrst_valid", {31'h0, bus.frame_valid}, 32'h0);
        check("midrst_err", {31'h0, bus.frame_err}, 32'h0);
`ifdef SSD_DEC_ERR_CNT_EN
        check("midrst_err_cnt", {24'h0, bus.err_cnt}, 32'h0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        show(3, 7'h12, 1'b1, 10);
        show(0, 7'h08, 1'b1, 10);
        show(1, 7'h03, 1'b1, 10);
        expect_frame(16'h5CBA, 4'h0, 1'b0);
        show(2, 7'h46, 1'b1, 10);
        idle(4'hF, TIMEOUT + 5);

        // Continuous rotation, 8 cycles per digit, dp lit on digit 3.
        for (int r = 0; r < 3; r++) begin
            show(0, 7'h78, 1'b1, 8);
            show(1, 7'h00, 1'b1, 8);
            show(2, 7'h10, 1'b1, 8);
            expect_frame(16'hA987, 4'h8, 1'b0);
            show(3, 7'h08, 1'b0, 8);
        end
        idle(4'hF, 10);
        check("rotation_period", last_pulse - prev_pulse, 32);

        check("pending_frames", exp_q.size(), 0);
        check("pulse_count", pulses, 8);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
